// File: rtl/seq_match_fsm.sv
// seq_match_fsm: programmable DEPTH-symbol sequence detector on a qualified
// symbol stream, with overlapping/non-overlapping match modes and a
// saturating match counter. q is a registered one-cycle pulse.
// Optional feature: define SEQ_CLEAR_EN to add a synchronous clear_i port.
module seq_match_fsm #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef SEQ_CLEAR_EN
  input  logic                         clear_i,
`endif
  input  logic                         valid_i,
  input  logic [W-1:0]                 sym_i,
  input  logic [W*DEPTH-1:0]           pattern_i,
  input  logic                         overlap_i,
  output logic                         q,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  // MATCH is the only state with bit 1 set, so q comes straight off a flop.
  typedef enum logic [1:0] {
    S_FILLING = 2'b00,
    S_ARMED   = 2'b01,
    S_MATCH   = 2'b10
  } state_t;

  state_t               state_q;
  logic [W*DEPTH-1:0]   hist_q;
  logic [FW-1:0]        fill_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [W*DEPTH-1:0]   shift_d;
  logic [FW-1:0]        fill_d;
  logic                 match_d;
  logic                 clr;

`ifdef SEQ_CLEAR_EN
  assign clr = clear_i;
`else
  assign clr = 1'b0;
`endif

  // Shifted window, saturating fill count and the combinational compare.
  always_comb begin
    shift_d = '0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      shift_d[i*W +: W] = hist_q[(i+1)*W +: W];
    end
    shift_d[(DEPTH-1)*W +: W] = sym_i;
    fill_d  = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match_d = valid_i && (fill_d == FULL) && (shift_d == pattern_i);
  end

  // Detector state, history, fill and counter; reset > clear > valid.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q <= S_FILLING;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else if (valid_i) begin
      hist_q <= shift_d;
      if (match_d) begin
        state_q <= S_MATCH;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        // With a single-symbol window restarting and staying full are the same.
        fill_q  <= (overlap_i || (DEPTH == 1)) ? FULL : '0;
      end else begin
        fill_q  <= fill_d;
        state_q <= (fill_d == FULL) ? S_ARMED : S_FILLING;
      end
    end else begin
      state_q <= (fill_q == FULL) ? S_ARMED : S_FILLING;
    end
  end

  assign q         = state_q[1];
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Directed bench for seq_match_fsm: a vector table for the default
// configuration plus hand sequences for the DEPTH=1 saturating instance
// and, when SEQ_CLEAR_EN is defined, the clear input.
module tb_seq_match_fsm;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: W=2, DEPTH=4, CNT_W=8
  logic       rst, vld, ov;
  logic [1:0] sym;
  logic [7:0] pat;
  logic       q;
  logic [7:0] cnt;
  logic [2:0] fl;
  logic       clr = 1'b0;

  // Small instance: W=2, DEPTH=1, CNT_W=2
  logic       rst2, vld2, ov2;
  logic [1:0] sym2, pat2;
  logic       q2;
  logic [1:0] cnt2;
  logic       fl2;
  logic       clr2 = 1'b0;

  seq_match_fsm #(.W(2), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(rst),
`ifdef SEQ_CLEAR_EN
    .clear_i(clr),
`endif
    .valid_i(vld), .sym_i(sym), .pattern_i(pat), .overlap_i(ov),
    .q(q), .match_cnt(cnt), .fill(fl)
  );

  seq_match_fsm #(.W(2), .DEPTH(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst2),
`ifdef SEQ_CLEAR_EN
    .clear_i(clr2),
`endif
    .valid_i(vld2), .sym_i(sym2), .pattern_i(pat2), .overlap_i(ov2),
    .q(q2), .match_cnt(cnt2), .fill(fl2)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] sym;
    logic [7:0] pat;
    logic       ov;
    logic       eq;
    logic [7:0] ecnt;
    logic [2:0] efill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [1:0] s,
                     input logic [7:0] p, input logic o,
                     input logic eq, input logic [7:0] ec, input logic [2:0] ef);
    vec_t t;
    t.rst = r; t.vld = v; t.sym = s; t.pat = p; t.ov = o;
    t.eq = eq; t.ecnt = ec; t.efill = ef;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step1(input int idx, input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] p, input logic o,
                       input logic eq, input logic [7:0] ec, input logic [2:0] ef);
    rst = r; vld = v; sym = s; pat = p; ov = o;
    @(posedge clk); #1;
    chk("q", idx, {31'd0, q}, {31'd0, eq});
    chk("match_cnt", idx, {24'd0, cnt}, {24'd0, ec});
    chk("fill", idx, {29'd0, fl}, {29'd0, ef});
  endtask

  task automatic step2(input int idx, input logic r, input logic v, input logic [1:0] s,
                       input logic o, input logic eq, input logic [1:0] ec, input logic ef);
    rst2 = r; vld2 = v; sym2 = s; ov2 = o; pat2 = 2'd2;
    @(posedge clk); #1;
    chk("d1_q", idx, {31'd0, q2}, {31'd0, eq});
    chk("d1_match_cnt", idx, {30'd0, cnt2}, {30'd0, ec});
    chk("d1_fill", idx, {31'd0, fl2}, {31'd0, ef});
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sym = '0; pat = '0; ov = 1'b0;
    rst2 = 1'b1; vld2 = 1'b0; sym2 = '0; pat2 = 2'd2; ov2 = 1'b0;

    // 1: reset held with valid symbols present
    add(1,1,3,8'hE4,1, 0,0,0);
    add(1,1,3,8'hE4,1, 0,0,0);
    add(1,1,3,8'hE4,1, 0,0,0);
    // 2: 0,1,2,3 against E4, overlap on -> fill stays 4
    add(0,1,0,8'hE4,1, 0,0,1);
    add(0,1,1,8'hE4,1, 0,0,2);
    add(0,1,2,8'hE4,1, 0,0,3);
    add(0,1,3,8'hE4,1, 1,1,4);
    add(0,0,3,8'hE4,1, 0,1,4);
    // 3a: six 1s against 55, overlapping
    add(1,0,0,8'h55,1, 0,0,0);
    add(0,1,1,8'h55,1, 0,0,1);
    add(0,1,1,8'h55,1, 0,0,2);
    add(0,1,1,8'h55,1, 0,0,3);
    add(0,1,1,8'h55,1, 1,1,4);
    add(0,1,1,8'h55,1, 1,2,4);
    add(0,1,1,8'h55,1, 1,3,4);
    // 3b: same stream, non-overlapping
    add(1,0,0,8'h55,0, 0,0,0);
    add(0,1,1,8'h55,0, 0,0,1);
    add(0,1,1,8'h55,0, 0,0,2);
    add(0,1,1,8'h55,0, 0,0,3);
    add(0,1,1,8'h55,0, 1,1,0);
    add(0,1,1,8'h55,0, 0,1,1);
    add(0,1,1,8'h55,0, 0,1,2);
    // 4: gap in valid_i does not break the sequence
    add(1,0,0,8'hE4,0, 0,0,0);
    add(0,1,0,8'hE4,0, 0,0,1);
    add(0,1,1,8'hE4,0, 0,0,2);
    add(0,0,3,8'hE4,0, 0,0,2);
    add(0,0,3,8'hE4,0, 0,0,2);
    add(0,0,3,8'hE4,0, 0,0,2);
    add(0,1,2,8'hE4,0, 0,0,3);
    add(0,1,3,8'hE4,0, 1,1,0);
    // 6: reset mid-sequence discards progress
    add(1,0,0,8'hE4,0, 0,0,0);
    add(0,1,0,8'hE4,0, 0,0,1);
    add(0,1,1,8'hE4,0, 0,0,2);
    add(0,1,2,8'hE4,0, 0,0,3);
    add(1,0,0,8'hE4,0, 0,0,0);
    add(0,1,3,8'hE4,0, 0,0,1);
    // full window without a match, then match, then pattern change mid-stream
    add(1,0,0,8'hE4,1, 0,0,0);
    add(0,1,3,8'hE4,1, 0,0,1);
    add(0,1,0,8'hE4,1, 0,0,2);
    add(0,1,1,8'hE4,1, 0,0,3);
    add(0,1,2,8'hE4,1, 0,0,4);
    add(0,1,3,8'hE4,1, 1,1,4);
    add(0,1,0,8'h39,1, 1,2,4);
    add(0,1,0,8'h39,1, 0,2,4);

    foreach (vecs[i])
      step1(i, vecs[i].rst, vecs[i].vld, vecs[i].sym, vecs[i].pat, vecs[i].ov,
            vecs[i].eq, vecs[i].ecnt, vecs[i].efill);

    // 5: DEPTH=1, CNT_W=2 -> every 2 pulses, counter saturates at 3
    step2(100, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      step2(100 + i, 0, 1, 2, i[0], 1, (i > 3) ? 2'd3 : 2'(i), 1);
    step2(108, 0, 1, 1, 0, 0, 3, 1);
    step2(109, 0, 0, 2, 0, 0, 3, 1);
    step2(110, 0, 1, 2, 0, 1, 3, 1);

`ifdef SEQ_CLEAR_EN
    // clear_i mirrors reset: partial sequence discarded, counter cleared
    step1(200, 1, 0, 0, 8'hE4, 1, 0, 0, 0);
    step1(201, 0, 1, 0, 8'hE4, 1, 0, 0, 1);
    step1(202, 0, 1, 1, 8'hE4, 1, 0, 0, 2);
    step1(203, 0, 1, 2, 8'hE4, 1, 0, 0, 3);
    step1(204, 0, 1, 3, 8'hE4, 1, 1, 1, 4);
    step1(205, 0, 1, 0, 8'hE4, 1, 0, 1, 4);
    step1(206, 0, 1, 1, 8'hE4, 1, 0, 1, 4);
    step1(207, 0, 1, 2, 8'hE4, 1, 0, 1, 4);
    clr = 1'b1;
    step1(208, 0, 0, 0, 8'hE4, 1, 0, 0, 0);
    clr = 1'b0;
    step1(209, 0, 1, 3, 8'hE4, 1, 0, 0, 1);
    // symbol presented together with clear is dropped
    clr = 1'b1;
    step1(210, 0, 1, 0, 8'hE4, 1, 0, 0, 0);
    clr = 1'b0;
    step1(211, 0, 1, 1, 8'hE4, 1, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
